// File: rtl/strip_mcu_reader.sv
// Reads a double-buffered 8-row strip bank back in 8x8 block order and streams the pixels
// with valid/ready. The buffer half is released as soon as its last read has been issued.
module strip_mcu_reader #(
  parameter int unsigned width_pix  = 320,
  parameter int unsigned height_pix = 240,
  parameter int unsigned num_ebr    = 5,
  parameter int unsigned ebr_size   = 512,
  localparam int unsigned sel_w     = (num_ebr > 1) ? $clog2(num_ebr) : 1,
  localparam int unsigned addr_w    = (ebr_size > 1) ? $clog2(ebr_size) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 strip_ready,
  input  logic                 strip_buffer,
  output logic [sel_w-1:0]     read_block_select,
  output logic                 read_buffer_select,
  output logic [addr_w-1:0]    read_addr,
  output logic                 read_en,
  input  logic [8*num_ebr-1:0] read_data,
  output logic [7:0]           pixel_out,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 start_of_block,
  output logic                 end_of_frame,
  output logic                 strip_done,
  output logic                 done_buffer,
  output logic                 overrun
);

  localparam int unsigned idx_w   = $clog2(width_pix * 8);
  localparam int unsigned blk_w   = (width_pix / 8 > 1) ? $clog2(width_pix / 8) : 1;
  localparam int unsigned strip_w = (height_pix / 8 > 1) ? $clog2(height_pix / 8) : 1;

  localparam logic [blk_w-1:0]   last_blk   = blk_w'(width_pix / 8 - 1);
  localparam logic [strip_w-1:0] last_strip = strip_w'(height_pix / 8 - 1);
  localparam logic [idx_w-1:0]   row_step   = idx_w'(width_pix - 7);
  // Two's-complement of 7*width_pix-1: steps back to row 0 of the next block.
  localparam logic [idx_w-1:0]   blk_step   = idx_w'(1 - 7 * int'(width_pix));

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  if ((width_pix % 8) != 0 || (height_pix % 8) != 0) begin : g_bad_dim
    $error("strip_mcu_reader: width_pix and height_pix must be multiples of 8");
  end
  if (width_pix * 8 > num_ebr * ebr_size) begin : g_bad_size
    $error("strip_mcu_reader: strip does not fit in one buffer half");
  end

  logic [0:0]         state_q, state_d;
  logic [2:0]         col_q, col_d, row_q, row_d;
  logic [blk_w-1:0]   blk_q, blk_d;
  logic [idx_w-1:0]   idx_q, idx_d;
  logic               buf_q, buf_d;
  logic               pend_q, pend_d, pend_buf_q, pend_buf_d;
  logic               overrun_q, overrun_d;
  logic [strip_w-1:0] strip_cnt_q, strip_cnt_d;
  logic               done_q, done_d, done_buf_q, done_buf_d;

  // One read in flight: EBR select and sideband flags ride along with read_en.
  logic               rd_vld_q;
  logic [sel_w-1:0]   rd_sel_q;
  logic               rd_sob_q, rd_eof_q;

  logic [9:0]         fifo_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         cnt_q;

  logic               last_read, issue, fifo_empty, push, pop;
  logic [2:0]         occ_next;
  logic [7:0]         rd_byte;
  logic [9:0]         in_entry, out_entry;
  logic [idx_w-1:0]   idx_hi;

  assign last_read  = (blk_q == last_blk) && (row_q == 3'd7) && (col_q == 3'd7);
  assign fifo_empty = (cnt_q == 2'd0);

  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < int'(num_ebr); k++) begin
      if (rd_sel_q == sel_w'(k)) rd_byte = read_data[8*k +: 8];
    end
  end

  // Fall-through FIFO: an empty FIFO presents the returning read directly.
  assign in_entry    = {rd_eof_q, rd_sob_q, rd_byte};
  assign out_entry   = !fifo_empty ? fifo_q[rd_ptr_q] : (rd_vld_q ? in_entry : '0);
  assign pixel_valid = !fifo_empty || rd_vld_q;
  assign pop         = pixel_valid && pixel_ready;
  assign push        = rd_vld_q && !(fifo_empty && pixel_ready);
  assign occ_next    = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign issue       = (state_q == StRead) && (occ_next < 3'd2);

  assign idx_hi             = idx_q >> addr_w;
  assign read_block_select  = sel_w'(idx_hi);
  assign read_addr          = addr_w'(idx_q);
  assign read_buffer_select = buf_q;
  assign read_en            = issue;

  assign pixel_out      = out_entry[7:0];
  assign start_of_block = out_entry[8];
  assign end_of_frame   = out_entry[9];
  assign strip_done     = done_q;
  assign done_buffer    = done_buf_q;
  assign overrun        = overrun_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    pend_buf_d  = pend_buf_q;
    overrun_d   = overrun_q;
    col_d       = col_q;
    row_d       = row_q;
    blk_d       = blk_q;
    idx_d       = idx_q;
    strip_cnt_d = strip_cnt_q;
    done_d      = 1'b0;
    done_buf_d  = done_buf_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StRead;
          buf_d   = pend_buf_q;
          pend_d  = strip_ready;
          if (strip_ready) pend_buf_d = strip_buffer;
        end else if (strip_ready) begin
          state_d = StRead;
          buf_d   = strip_buffer;
        end
      end
      StRead: begin
        if (strip_ready) begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d     = 1'b1;
            pend_buf_d = strip_buffer;
          end
        end
        if (issue) begin
          if (last_read) begin
            col_d       = '0;
            row_d       = '0;
            blk_d       = '0;
            idx_d       = '0;
            state_d     = StIdle;
            done_d      = 1'b1;
            done_buf_d  = buf_q;
            strip_cnt_d = (strip_cnt_q == last_strip) ? '0 : strip_cnt_q + 1'b1;
          end else if (col_q != 3'd7) begin
            col_d = col_q + 3'd1;
            idx_d = idx_q + idx_w'(1);
          end else if (row_q != 3'd7) begin
            col_d = '0;
            row_d = row_q + 3'd1;
            idx_d = idx_q + row_step;
          end else begin
            col_d = '0;
            row_d = '0;
            blk_d = blk_q + 1'b1;
            idx_d = idx_q + blk_step;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      buf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_buf_q  <= 1'b0;
      overrun_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      blk_q       <= '0;
      idx_q       <= '0;
      strip_cnt_q <= '0;
      done_q      <= 1'b0;
      done_buf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      pend_buf_q  <= pend_buf_d;
      overrun_q   <= overrun_d;
      col_q       <= col_d;
      row_q       <= row_d;
      blk_q       <= blk_d;
      idx_q       <= idx_d;
      strip_cnt_q <= strip_cnt_d;
      done_q      <= done_d;
      done_buf_q  <= done_buf_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_sel_q  <= '0;
      rd_sob_q  <= 1'b0;
      rd_eof_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_sel_q <= read_block_select;
        rd_sob_q <= (row_q == 3'd0) && (col_q == 3'd0);
        rd_eof_q <= last_read && (strip_cnt_q == last_strip);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= in_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop && !fifo_empty) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop && !fifo_empty};
    end
  end

endmodule

// File: tb/tb_strip_mcu_reader.sv
// Self-checking bench for strip_mcu_reader: EBR bank model, block-order pixel scoreboard,
// directed read-address table and multi-cycle corner sequences.
module tb_strip_mcu_reader;

  localparam int W      = 320;
  localparam int H      = 48;
  localparam int NE     = 5;
  localparam int ES     = 512;
  localparam int SPP    = W * 8;
  localparam int NSTRIP = H / 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            strip_ready, strip_buffer;
  logic [2:0]      read_block_select;
  logic            read_buffer_select;
  logic [8:0]      read_addr;
  logic            read_en;
  logic [8*NE-1:0] read_data = '0;
  logic [7:0]      pixel_out;
  logic            pixel_valid, pixel_ready;
  logic            start_of_block, end_of_frame, strip_done, done_buffer, overrun;

  strip_mcu_reader #(
    .width_pix (W),
    .height_pix(H),
    .num_ebr   (NE),
    .ebr_size  (ES)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .strip_ready       (strip_ready),
    .strip_buffer      (strip_buffer),
    .read_block_select (read_block_select),
    .read_buffer_select(read_buffer_select),
    .read_addr         (read_addr),
    .read_en           (read_en),
    .read_data         (read_data),
    .pixel_out         (pixel_out),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .start_of_block    (start_of_block),
    .end_of_frame      (end_of_frame),
    .strip_done        (strip_done),
    .done_buffer       (done_buffer),
    .overrun           (overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [7:0] pix; logic sob; logic eof;} pix_t;
  typedef struct {logic b; int e; int a; int cyc;} rd_t;
  typedef struct {pix_t p; int cyc;} rx_t;
  typedef struct {int n; int e; int a; logic sob;} vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_strip = 0;
  bit   rnd_ready = 0;
  pix_t exp_q[$];
  rd_t  rd_log[$];
  rx_t  rx_log[$];
  int   done_cyc_log[$];
  logic done_buf_log[$];
  int   eof_log[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic b, input int idx);
    return b ? 8'((idx * 13 + 7) % 256) : 8'(idx % 251);
  endfunction

  // Reference order: blocks left to right, each block row-major; idx = row*W + blk*8 + col.
  task automatic expect_strip(input logic b);
    pix_t e;
    for (int n = 0; n < SPP; n++) begin
      int blk = n / 64;
      int r   = (n % 64) / 8;
      int c   = n % 8;
      e.pix = mem_byte(b, r * W + blk * 8 + c);
      e.sob = (n % 64) == 0;
      e.eof = (n == SPP - 1) && (model_strip == NSTRIP - 1);
      exp_q.push_back(e);
    end
    model_strip = (model_strip + 1) % NSTRIP;
  endtask

  // EBR bank: only the selected EBR returns real data; the others return noise.
  always @(posedge clock) begin
    if (read_en) begin
      for (int k = 0; k < NE; k++) begin
        read_data[8*k +: 8] <= (k == int'(read_block_select))
            ? mem_byte(read_buffer_select, int'(read_block_select) * ES + int'(read_addr))
            : 8'($urandom);
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    pixel_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 pixel_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  logic prev_stall = 1'b0;
  pix_t prev_pix;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      pix_t act;
      act = {pixel_out, start_of_block, end_of_frame};
      if (read_en) rd_log.push_back('{read_buffer_select, int'(read_block_select),
                                      int'(read_addr), cyc});
      if (strip_done) begin
        done_cyc_log.push_back(cyc);
        done_buf_log.push_back(done_buffer);
      end
      if (prev_stall) check("stall_hold", {pixel_valid, act}, {1'b1, prev_pix});
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check("stream {pix,sob,eof}", act, e);
        end
        if (end_of_frame) eof_log.push_back(rx_log.size());
        rx_log.push_back('{act, cyc});
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix   = act;
    end
  end

  task automatic pulse(input logic b);
    @(posedge clock);
    #1 strip_ready = 1'b1;
    strip_buffer = b;
    @(posedge clock);
    #1 strip_ready = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain_timeout_remaining", exp_q.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  function automatic longint unsigned all_outputs();
    return {read_block_select, read_buffer_select, read_addr, read_en, pixel_out, pixel_valid,
            start_of_block, end_of_frame, strip_done, done_buffer, overrun};
  endfunction

  vec_t tbl[7];
  int   rd_base, rx_base, dn_base, eof_base, b1_first;

  initial begin
    reset        = 1'b1;
    strip_ready  = 1'b0;
    strip_buffer = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", all_outputs(), 0);
    reset = 1'b0;

    // Strip of buffer 0 at full rate, with first-read latency.
    tbl[0] = '{0, 0, 0, 1'b1};
    tbl[1] = '{1, 0, 1, 1'b0};
    tbl[2] = '{2, 0, 2, 1'b0};
    tbl[3] = '{8, 0, 320, 1'b0};
    tbl[4] = '{16, 1, 128, 1'b0};
    tbl[5] = '{64, 0, 8, 1'b1};
    tbl[6] = '{SPP - 1, 4, 511, 1'b0};
    rd_base = rd_log.size(); rx_base = rx_log.size(); dn_base = done_cyc_log.size();
    expect_strip(1'b0);
    @(posedge clock);
    #1 strip_ready = 1'b1;
    strip_buffer = 1'b0;
    @(negedge clock);
    check("latency_read_en_same_cycle", read_en, 0);
    @(posedge clock);
    #1 strip_ready = 1'b0;
    @(negedge clock);
    check("latency_read_en_next", read_en, 1);
    check("latency_valid_early", pixel_valid, 0);
    @(negedge clock);
    check("latency_valid", pixel_valid, 1);
    drain(4000);
    check("t1_reads", rd_log.size() - rd_base, SPP);
    check("t1_pixels", rx_log.size() - rx_base, SPP);
    for (int i = 0; i < 7; i++) begin
      if (rd_log.size() > rd_base + tbl[i].n && rx_log.size() > rx_base + tbl[i].n) begin
        check($sformatf("t1_read%0d_ebr", tbl[i].n + 1), rd_log[rd_base + tbl[i].n].e, tbl[i].e);
        check($sformatf("t1_read%0d_addr", tbl[i].n + 1), rd_log[rd_base + tbl[i].n].a,
              tbl[i].a);
        check($sformatf("t1_read%0d_buf", tbl[i].n + 1), rd_log[rd_base + tbl[i].n].b, 0);
        check($sformatf("t1_pix%0d_sob", tbl[i].n + 1), rx_log[rx_base + tbl[i].n].p.sob,
              tbl[i].sob);
      end else begin
        check("t1_log_short", 0, 1);
      end
    end
    if (rx_log.size() >= rx_base + SPP)
      check("t1_contiguous", rx_log[rx_base + SPP - 1].cyc - rx_log[rx_base].cyc, SPP - 1);
    check("t1_strip_done_count", done_cyc_log.size() - dn_base, 1);
    if (done_buf_log.size() > dn_base) check("t1_done_buffer", done_buf_log[dn_base], 0);

    // Same strip with random backpressure.
    rx_base = rx_log.size(); dn_base = done_cyc_log.size();
    rnd_ready = 1;
    expect_strip(1'b0);
    pulse(1'b0);
    drain(9000);
    rnd_ready = 0;
    check("t2_pixels", rx_log.size() - rx_base, SPP);
    check("t2_strip_done_count", done_cyc_log.size() - dn_base, 1);

    // Buffer 1 queued 100 cycles in; starts the cycle after strip_done(0).
    rd_base = rd_log.size(); dn_base = done_cyc_log.size();
    expect_strip(1'b0);
    expect_strip(1'b1);
    pulse(1'b0);
    repeat (100) @(posedge clock);
    pulse(1'b1);
    drain(7000);
    check("t3_strip_done_count", done_cyc_log.size() - dn_base, 2);
    b1_first = -1;
    for (int i = rd_base; i < rd_log.size(); i++) begin
      if (rd_log[i].b && b1_first < 0) b1_first = i;
    end
    if (b1_first >= 0 && done_cyc_log.size() >= dn_base + 2) begin
      check("t3_b1_start_cycle", rd_log[b1_first].cyc, done_cyc_log[dn_base] + 1);
      check("t3_b1_first_addr", {rd_log[b1_first].e, rd_log[b1_first].a}, 0);
      check("t3_done_buffer0", done_buf_log[dn_base], 0);
      check("t3_done_buffer1", done_buf_log[dn_base + 1], 1);
    end else begin
      check("t3_b1_missing", 0, 1);
    end
    check("t3_no_overrun", overrun, 0);

    // Three requests during one strip: the third overruns, two strips are output.
    rx_base = rx_log.size(); dn_base = done_cyc_log.size();
    expect_strip(1'b0);
    expect_strip(1'b1);
    pulse(1'b0);
    repeat (50) @(posedge clock);
    pulse(1'b1);
    @(negedge clock);
    check("t4_overrun_after_two", overrun, 0);
    pulse(1'b0);
    @(negedge clock);
    check("t4_overrun_after_three", overrun, 1);
    drain(7000);
    check("t4_strip_done_count", done_cyc_log.size() - dn_base, 2);
    check("t4_pixels", rx_log.size() - rx_base, 2 * SPP);
    check("t4_overrun_sticky", overrun, 1);

    // Full frame plus one strip: end_of_frame only on the frame's last pixel.
    @(negedge clock) reset = 1'b1;
    model_strip = 0;
    @(negedge clock);
    check("t5_overrun_cleared", overrun, 0);
    reset = 1'b0;
    rx_base = rx_log.size(); eof_base = eof_log.size();
    for (int s = 0; s <= NSTRIP; s++) begin
      expect_strip(1'(s % 2));
      pulse(1'(s % 2));
      drain(4000);
    end
    check("t5_pixels", rx_log.size() - rx_base, SPP * (NSTRIP + 1));
    check("t5_eof_count", eof_log.size() - eof_base, 1);
    if (eof_log.size() > eof_base)
      check("t5_eof_position", eof_log[eof_base] - rx_base, SPP * NSTRIP - 1);

    // Reset mid-strip at pixel 1000, then a clean restart.
    rx_base = rx_log.size();
    expect_strip(1'b0);
    pulse(1'b0);
    begin
      int k = 0;
      while (rx_log.size() - rx_base < 1000 && k < 3000) begin
        @(negedge clock);
        k++;
      end
      check("t6_reach_pixel_1000", rx_log.size() - rx_base >= 1000, 1);
    end
    #1 reset = 1'b1;
    #1 check("t6_async_reset_outputs", all_outputs(), 0);
    exp_q.delete();
    model_strip = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd_base = rd_log.size(); rx_base = rx_log.size();
    expect_strip(1'b1);
    pulse(1'b1);
    drain(4000);
    if (rd_log.size() > rd_base)
      check("t6_restart_read", {rd_log[rd_base].b, rd_log[rd_base].e, rd_log[rd_base].a},
            {1'b1, 32'd0, 32'd0});
    else
      check("t6_restart_missing", 0, 1);
    check("t6_pixels", rx_log.size() - rx_base, SPP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
